// File: rtl/fifo_rd_arbiter_pkg.sv
// Shared types and helpers for the FIFO read arbiter.
// State encodings plus a constant-safe clog2.
package fifo_rd_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Scans upward from last+1, wrapping, for the first set request bit.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         found,
  output logic [W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(last) + k) % N]) begin
        found = 1'b1;
        idx   = W'((int'(last) + k) % N);
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst reader sharing one stream sink across FIFO read ports.
// FIFO_RD_ARB_CHID_EN adds the registered out_chan source-index port.
module fifo_rd_arbiter
  import fifo_rd_arbiter_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DATA_SIZE = 8,
  parameter int BURST     = 4,
  localparam int CW       = clog2(NUM_CH)
) (
  input  logic                        r_clk,
  input  logic                        r_rst_n,
  input  logic [NUM_CH-1:0]           r_empty,
  input  logic [NUM_CH*DATA_SIZE-1:0] r_data,
  output logic [NUM_CH-1:0]           r_inc,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [DATA_SIZE-1:0]        out_data
`ifdef FIFO_RD_ARB_CHID_EN
  ,
  output logic [CW-1:0]               out_chan
`endif
);

  localparam int NW = clog2(BURST) + 1;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] grant;
  logic [CW-1:0] last;
  logic [NW-1:0] cnt;
  logic          found;
  logic [CW-1:0] pick;
  logic          cur_empty;
  logic          can_load;
  logic          pop;
  logic          last_beat;

  rr_pick #(
    .N(NUM_CH),
    .W(CW)
  ) u_pick (
    .req  (~r_empty),
    .last (last),
    .found(found),
    .idx  (pick)
  );

  assign cur_empty = r_empty[grant];
  assign can_load  = !out_valid || out_ready;
  assign last_beat = cnt == NW'(BURST - 1);
  // Pops are gated by reset so a mid-burst reset stops traffic at once.
  assign pop = r_rst_n && (state == ST_XFER)
            && !cur_empty && can_load;

  always_comb begin
    r_inc        = '0;
    r_inc[grant] = pop;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (found) state_nx = ST_XFER;
      ST_XFER: begin
        if (cur_empty) state_nx = ST_IDLE;
        else if (pop && last_beat) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (!r_rst_n) state <= ST_IDLE;
    else state <= state_nx;
  end

  always_ff @(posedge r_clk) begin
    if (!r_rst_n) begin
      grant     <= '0;
      last      <= CW'(NUM_CH - 1);
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef FIFO_RD_ARB_CHID_EN
      out_chan  <= '0;
`endif
    end else begin
      if (state == ST_IDLE && found) begin
        grant <= pick;
        last  <= pick;
        cnt   <= '0;
      end
      if (pop) begin
        out_data  <= r_data[int'(grant)*DATA_SIZE +: DATA_SIZE];
        out_valid <= 1'b1;
        cnt       <= cnt + NW'(1);
`ifdef FIFO_RD_ARB_CHID_EN
        out_chan  <= grant;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Scoreboard bench for fifo_rd_arbiter with behavioural FIFOs.
// Expected output order comes from a transaction-level round-robin model.
module tb_fifo_rd_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int B  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    r_empty;
  logic [N*DW-1:0] r_data;
  logic [N-1:0]    r_inc;
  logic            out_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
`ifdef FIFO_RD_ARB_CHID_EN
  logic [1:0]      out_chan;
`endif

  fifo_rd_arbiter #(
    .NUM_CH(N),
    .DATA_SIZE(DW),
    .BURST(B)
  ) dut (
    .r_clk    (clk),
    .r_rst_n  (rst_n),
    .r_empty  (r_empty),
    .r_data   (r_data),
    .r_inc    (r_inc),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data)
`ifdef FIFO_RD_ARB_CHID_EN
    ,
    .out_chan (out_chan)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fq[N][$];
  logic [DW-1:0] sb[$];
  int            pop_cyc[$];
  int            pop_ch[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            ready_mode = 0;
  logic [N-1:0]  pend = '0;
  bit            rst_seen = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Behavioural FIFOs: pop on captured r_inc, then present front word.
  always @(posedge clk) begin
    cyc++;
    rst_seen = !rst_n;
    for (int i = 0; i < N; i++) begin
      if (pend[i] && fq[i].size() > 0) begin
        void'(fq[i].pop_front());
        pop_cyc.push_back(cyc);
        pop_ch.push_back(i);
      end
    end
    #1;
    for (int i = 0; i < N; i++) begin
      r_empty[i] = fq[i].size() == 0;
      r_data[i*DW +: DW] = fq[i].size() > 0 ? fq[i][0] : '0;
    end
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = (cyc % 3) == 0;
      default: out_ready = $urandom_range(0, 9) < 7;
    endcase
  end

  // Monitor: scoreboard pops on handshake plus interface invariants.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      chk(r_inc == '0, "rst_inc", 32'(r_inc), 0);
      if (rst_seen) chk(!out_valid, "rst_valid", 32'(out_valid), 0);
      prev_stall = 1'b0;
      pend = '0;
    end else begin
      chk($onehot0(r_inc), "onehot", 32'(r_inc), 0);
      for (int i = 0; i < N; i++)
        if (r_inc[i])
          chk(fq[i].size() > 0 && !r_empty[i], "pop_empty", i, 0);
      if (out_valid && !out_ready)
        chk(r_inc == '0, "bp_inc", 32'(r_inc), 0);
      if (prev_stall)
        chk(out_valid && out_data == prev_data, "hold",
            32'(out_data), 32'(prev_data));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk(1'b0, "sb_underflow", 32'(out_data), 0);
        end else begin
          logic [DW-1:0] e;
          e = sb.pop_front();
          chk(out_data == e, "data", 32'(out_data), 32'(e));
        end
`ifdef FIFO_RD_ARB_CHID_EN
        chk(out_chan == out_data[7:6], "chan",
            32'(out_chan), 32'(out_data[7:6]));
`endif
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      pend = r_inc;
    end
  end

  // Transaction-level model: static FIFO contents, rr over non-empty
  // channels starting after channel N-1, min(B, remaining) words each.
  task automatic build_expected();
    int rem[N];
    int rd[N];
    int last;
    int sel;
    int n;
    last = N - 1;
    for (int i = 0; i < N; i++) begin
      rem[i] = fq[i].size();
      rd[i]  = 0;
    end
    for (int g = 0; g < 1000; g++) begin
      sel = -1;
      for (int k = 1; k <= N; k++)
        if (sel < 0 && rem[(last + k) % N] > 0) sel = (last + k) % N;
      if (sel < 0) break;
      n = rem[sel] < B ? rem[sel] : B;
      for (int j = 0; j < n; j++) sb.push_back(fq[sel][rd[sel] + j]);
      rd[sel]  += n;
      rem[sel] -= n;
      last = sel;
    end
  endtask

  task automatic load(input int ch, input int cnt);
    for (int j = 0; j < cnt; j++) fq[ch].push_back({2'(ch), 6'(j)});
  endtask

  task automatic enter_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Release before an edge P0; return at P0 with the model loaded.
  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    pop_cyc.delete();
    pop_ch.delete();
    @(posedge clk);
    build_expected();
  endtask

  task automatic wait_drain(input int max);
    int k;
    bit busy;
    k = 0;
    busy = 1'b1;
    while (busy && k < max) begin
      @(negedge clk);
      k++;
      busy = sb.size() != 0 || out_valid;
      for (int i = 0; i < N; i++) if (fq[i].size() != 0) busy = 1'b1;
    end
    chk(k < max, "drain_timeout", k, max);
    chk(sb.size() == 0, "sb_left", sb.size(), 0);
  endtask

  initial begin
    r_empty   = '1;
    r_data    = '0;
    out_ready = 1'b1;

    // Idle: nothing to read for 10 cycles.
    enter_reset();
    release_reset();
    for (int c = 0; c < 10; c++) begin
      #2;
      chk(!out_valid && r_inc == '0, "idle",
          {out_valid, 4'(r_inc)}, 0);
      @(posedge clk);
    end

    // Single channel latency: grant at P0, word A visible after P1.
    enter_reset();
    fq[2].push_back(8'hA1);
    fq[2].push_back(8'hB2);
    fq[2].push_back(8'hC3);
    @(posedge clk);
    release_reset();
    #2;
    chk(r_inc == 4'b0100 && !out_valid, "lat_p0",
        {out_valid, 4'(r_inc)}, 32'h04);
    @(posedge clk);
    #2;
    chk(out_valid && out_data == 8'hA1, "lat_p1",
        32'(out_data), 32'hA1);
    wait_drain(50);
    chk(pop_cyc.size() == 3 && pop_cyc[2] - pop_cyc[0] == 2,
        "ch2_b2b", pop_cyc.size(), 3);

    // Full FIFOs, no backpressure: 8 bursts with one idle cycle between.
    enter_reset();
    for (int i = 0; i < N; i++) load(i, 8);
    @(posedge clk);
    release_reset();
    wait_drain(200);
    chk(pop_cyc.size() == 32, "full_pops", pop_cyc.size(), 32);
    if (pop_cyc.size() == 32) begin
      bit ok;
      ok = 1'b1;
      for (int k = 0; k < 32; k++) if (pop_ch[k] != (k / 4) % 4) ok = 1'b0;
      chk(ok, "full_order", 0, 1);
      chk(pop_cyc[31] - pop_cyc[0] == 38, "full_span",
          pop_cyc[31] - pop_cyc[0], 38);
    end

    // Backpressure on a single channel.
    enter_reset();
    ready_mode = 1;
    load(1, 5);
    @(posedge clk);
    release_reset();
    wait_drain(200);
    chk(pop_cyc.size() == 5, "bp_pops", pop_cyc.size(), 5);

    // Reset mid-burst after two pops of channel 0.
    enter_reset();
    ready_mode = 0;
    for (int i = 0; i < N; i++) load(i, 8);
    @(posedge clk);
    release_reset();
    for (int k = 0; k < 20 && fq[0].size() > 6; k++) @(posedge clk);
    chk(fq[0].size() == 6, "mid_pops", fq[0].size(), 6);
    #3 rst_n = 1'b0;
    @(posedge clk);
    #2;
    chk(!out_valid && r_inc == '0, "mid_rst",
        {out_valid, 4'(r_inc)}, 0);
    @(posedge clk);
    release_reset();
    #2;
    chk(r_inc == 4'b0001, "mid_regrant", 32'(r_inc), 1);
    wait_drain(300);

    // Randomised contents and random backpressure.
    ready_mode = 2;
    for (int t = 0; t < 6; t++) begin
      enter_reset();
      for (int i = 0; i < N; i++) load(i, $urandom_range(0, 11));
      @(posedge clk);
      release_reset();
      wait_drain(600);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0d expected=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
